// File: rtl/fifo_read_ptr_ctrl_if.sv
// Read-side FIFO pointer bus: pop request, async Gray write pointer in, read pointers and level flags out.
// master is the pop client / write-domain bridge; slave is the pointer controller.
interface fifo_read_ptr_ctrl_if #(
  parameter int p_num_entries = 8,
  parameter int p_max_pop     = 1
);
  localparam int p_ptr_width = $clog2(p_num_entries) + 1;
  localparam int p_num_width = $clog2(p_max_pop + 1);

  logic [p_ptr_width-1:0] g_write_ptr_async;
  logic                   r_en;
  logic [p_num_width-1:0] r_num;
  logic                   clr_underflow;
  logic [p_ptr_width-1:0] b_read_ptr;
  logic [p_ptr_width-1:0] g_read_ptr;
  logic [p_ptr_width-2:0] r_addr;
  logic [p_ptr_width-1:0] occupancy;
  logic                   empty;
  logic                   almost_empty;
  logic                   underflow;

  modport master (
    output g_write_ptr_async, r_en, r_num, clr_underflow,
    input  b_read_ptr, g_read_ptr, r_addr, occupancy, empty, almost_empty, underflow
  );

  modport slave (
    input  g_write_ptr_async, r_en, r_num, clr_underflow,
    output b_read_ptr, g_read_ptr, r_addr, occupancy, empty, almost_empty, underflow
  );
endinterface

// File: rtl/fifo_read_ptr_ctrl.sv
// Async FIFO read-domain pointer controller: synchronizes the Gray write pointer, tracks read pointers, flags.
// Pops land on the next edge; writes show after p_sync_stages edges; over-pops are refused and latch underflow.
module fifo_read_ptr_ctrl #(
  parameter int p_num_entries         = 8,
  parameter int p_sync_stages         = 2,
  parameter int p_max_pop             = 1,
  parameter int p_almost_empty_thresh = 1
) (
  input logic                 clk,
  input logic                 reset,
  fifo_read_ptr_ctrl_if.slave bus
);
  localparam int p_ptr_width = $clog2(p_num_entries) + 1;
  localparam int p_num_width = $clog2(p_max_pop + 1);

  typedef logic [p_ptr_width-1:0] ptr_t;

  localparam ptr_t c_ae_thresh = ptr_t'(p_almost_empty_thresh);

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[p_ptr_width-1] = g[p_ptr_width-1];
    for (int i = p_ptr_width - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  ptr_t                   sync_q [p_sync_stages];
  ptr_t                   b_wsync;
  ptr_t                   b_rptr_q;
  ptr_t                   g_rptr_q;
  ptr_t                   b_rptr_nxt;
  ptr_t                   occ_raw;
  ptr_t                   num_ext;
  ptr_t                   grant;
  logic [p_num_width-1:0] r_num_w;
  logic                   underflow_q;
  logic                   over_pop;

  // Pops are judged only against the synced occupancy held in registers this cycle.
  assign b_wsync    = gray2bin(sync_q[p_sync_stages-1]);
  assign occ_raw    = b_wsync - b_rptr_q;
  assign r_num_w    = bus.r_num;
  assign num_ext    = ptr_t'(r_num_w);
  assign over_pop   = bus.r_en && (num_ext > occ_raw);
  assign grant      = (bus.r_en && !over_pop) ? num_ext : '0;
  assign b_rptr_nxt = b_rptr_q + grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_sync_stages; i++) begin
        sync_q[i] <= '0;
      end
      b_rptr_q    <= '0;
      g_rptr_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.g_write_ptr_async;
      for (int i = 1; i < p_sync_stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      b_rptr_q <= b_rptr_nxt;
      g_rptr_q <= bin2gray(b_rptr_nxt);
      // Set has priority over clear so a same-cycle over-pop is never lost.
      if (over_pop) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_underflow) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.b_read_ptr   = b_rptr_q;
  assign bus.g_read_ptr   = g_rptr_q;
  assign bus.r_addr       = b_rptr_q[p_ptr_width-2:0];
  assign bus.underflow    = underflow_q;
  assign bus.occupancy    = reset ? '0 : occ_raw;
  assign bus.empty        = reset || (occ_raw == '0);
  assign bus.almost_empty = reset || (occ_raw <= c_ae_thresh);
endmodule
